tnkiii_back1_cpu_port: RTL

CPU-side initiator for the TNK III Back1 background layer. Decodes Z80 bus cycles into the timed Back1 VRAM access sequence and the scroll/control register strobes. Holds the CPU with a wait handshake until each access completes. Sits between the main CPU bus and the Back1 layer, which is the responder on the VA/VD/strobe interface.

---
 rtl/tnkiii_back1_cpu_port.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/tnkiii_back1_cpu_port.sv
// CPU-side initiator for the TNK III Back1 layer: Z80 bus cycles -> timed VRAM access and scroll/control strobes.
// Define BACK1_READBACK_EN to run VRAM reads through the full access sequence; otherwise reads return 8'hFF with no wait.
module tnkiii_back1_cpu_port #(
    parameter logic [15:0] VRAM_BASE  = 16'hD800,
    parameter logic [15:0] SY_ADDR    = 16'hC900,
    parameter logic [15:0] SX_ADDR    = 16'hC980,
    parameter logic [15:0] MSB_ADDR   = 16'hC800,
    parameter int unsigned STROBE_CYC = 2
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        CK1n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    input  logic        cpu_req,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    output logic        cpu_waitn,
    output logic [12:0] VA,
    output logic [7:0]  VD_out,
    input  logic [7:0]  VD_in,
    output logic        BACK1_VRAM_CSn,
    output logic        V_C,
    output logic        VRD,
    output logic        VDG,
    output logic        VOE,
    output logic        VWE,
    output logic        B1SX,
    output logic        B1SY,
    output logic        B1X8,
    output logic        B1Y8,
    output logic        B1_COLBK
);

`ifdef BACK1_READBACK_EN
    localparam logic READBACK = 1'b1;
`else
    localparam logic READBACK = 1'b0;
`endif

    localparam logic [16:0] VRAM_END = {1'b0, VRAM_BASE} + 17'd8192;
    localparam logic [2:0]  LAST_STB = 3'(STROBE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAITSLOT,
        S_ADDR,
        S_STROBE,
        S_CAPTURE,
        S_RDATA,
        S_RSTB,
        S_RELEASE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_req_d;
    logic [12:0] r_va;
    logic [7:0]  r_din;
    logic        r_wr;
    logic        r_sx;
    logic [7:0]  r_dout;
    logic [2:0]  r_cnt;
    logic        r_x8;
    logic        r_y8;
    logic        r_colbk;

    logic        w_new;
    logic        w_vram_hit;
    logic        w_vram_go;
    logic        w_scroll_go;
    logic        w_msb_go;
    logic [12:0] w_va;

    // A request is the rising edge of cpu_req with exactly one direction; only IDLE accepts it.
    assign w_new       = cpu_req & ~r_req_d & (cpu_rd ^ cpu_wr) & (r_state == S_IDLE) & ~RESET;
    assign w_vram_hit  = (cpu_addr >= VRAM_BASE) && ({1'b0, cpu_addr} < VRAM_END);
    assign w_vram_go   = w_new & w_vram_hit & (cpu_wr | READBACK);
    assign w_scroll_go = w_new & cpu_wr & ((cpu_addr == SX_ADDR) || (cpu_addr == SY_ADDR));
    assign w_msb_go    = w_new & cpu_wr & (cpu_addr == MSB_ADDR);
    assign w_va        = 13'(cpu_addr - VRAM_BASE);

    assign cpu_dout = READBACK ? r_dout : 8'hFF;
    assign B1X8     = r_x8;
    assign B1Y8     = r_y8;
    assign B1_COLBK = r_colbk;

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_req_d <= 1'b0;
            r_va    <= '0;
            r_din   <= '1;
            r_wr    <= 1'b0;
            r_sx    <= 1'b0;
            r_dout  <= '1;
            r_cnt   <= '0;
            r_x8    <= 1'b0;
            r_y8    <= 1'b0;
            r_colbk <= 1'b0;
        end else begin
            r_state <= w_next;
            r_req_d <= cpu_req;
            if (w_vram_go || w_scroll_go) begin
                r_va  <= w_va;
                r_din <= cpu_din;
                r_wr  <= cpu_wr;
                r_sx  <= (cpu_addr == SX_ADDR);
            end
            if (r_state == S_STROBE) begin
                r_cnt <= r_cnt + 3'd1;
            end else begin
                r_cnt <= '0;
            end
            // Read data is taken from the layer on the edge that closes the last strobe cycle.
            if (READBACK && (r_state == S_STROBE) && (r_cnt == LAST_STB) && !r_wr) begin
                r_dout <= VD_in;
            end
            if (w_msb_go) begin
                r_x8    <= cpu_din[4];
                r_y8    <= cpu_din[5];
                r_colbk <= cpu_din[6];
            end
        end
    end

    always_comb begin
        w_next         = r_state;
        cpu_waitn      = 1'b1;
        VA             = '0;
        VD_out         = '1;
        BACK1_VRAM_CSn = 1'b1;
        V_C            = 1'b0;
        VRD            = 1'b0;
        VDG            = 1'b1;
        VOE            = 1'b1;
        VWE            = 1'b1;
        B1SX           = 1'b0;
        B1SY           = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_vram_go) begin
                    cpu_waitn = 1'b0;
                    w_next    = CK1n ? S_ADDR : S_WAITSLOT;
                end else if (w_scroll_go) begin
                    cpu_waitn = 1'b0;
                    w_next    = S_RDATA;
                end
            end
            S_WAITSLOT: begin
                cpu_waitn = 1'b0;
                if (CK1n) begin
                    w_next = S_ADDR;
                end
            end
            S_ADDR, S_STROBE, S_CAPTURE: begin
                // Address/CS bracket the strobes by one clock on each side.
                cpu_waitn      = 1'b0;
                VA             = r_va;
                BACK1_VRAM_CSn = 1'b0;
                V_C            = 1'b1;
                VRD            = r_wr;
                if (r_wr) begin
                    VD_out = r_din;
                end
                if (r_state == S_ADDR) begin
                    w_next = S_STROBE;
                end else if (r_state == S_STROBE) begin
                    VDG = 1'b0;
                    VOE = r_wr;
                    VWE = ~r_wr;
                    if (r_cnt == LAST_STB) begin
                        w_next = S_CAPTURE;
                    end
                end else begin
                    w_next = S_RELEASE;
                end
            end
            S_RDATA: begin
                cpu_waitn = 1'b0;
                VD_out    = r_din;
                w_next    = S_RSTB;
            end
            S_RSTB: begin
                cpu_waitn = 1'b0;
                VD_out    = r_din;
                B1SX      = r_sx;
                B1SY      = ~r_sx;
                w_next    = S_RELEASE;
            end
            S_RELEASE: begin
                if (!cpu_req) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule
